// File: rtl/memif_boot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memif_arb_pkg
//   Shared types and widths for the boot/run memory-interface arbiter.
//   - req_id_e : requester identity, also the tag stored per outstanding read
//   - phase_e  : arbiter phase (boot loader only / drain / run)
//   - mem_req_t: one request's payload, used to mux a requester onto the port
//   - is_read(): decodes the shared RW convention (0 = read, 1 = write)
// -----------------------------------------------------------------------------
package memif_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int DQM_W  = 4;

  typedef enum logic [1:0] {
    IBOOT = 2'd0,
    INST  = 2'd1,
    DATA  = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } phase_e;

  typedef struct packed {
    logic [DQM_W-1:0]  dqm;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  function automatic logic is_read(input mem_req_t req);
    return !req.rw;
  endfunction

endpackage

// File: rtl/memif_boot_arbiter_if.sv
// -----------------------------------------------------------------------------
// memif_boot_arbiter_if
//   Bundles every non-clock signal of the arbiter.
//   Handshake (all request ports, requester side and memory side alike):
//     a request transfers in a cycle where its VALID is high and its LOCK is
//     low; while LOCK is high the issuer keeps VALID and all fields stable.
//     Read responses (iMEM_RD_*) and routed responses (o*_RD_*) are one-cycle
//     strobes with no backpressure.
//   Modports:
//     master - the arbiter itself (drives the o* signals)
//     slave  - the surrounding system (drives the i* signals)
// -----------------------------------------------------------------------------
interface memif_boot_arbiter_if;
  import memif_arb_pkg::*;

  // Boot loader status
  logic              iIBOOT_VALID;

  // Requester IBOOT
  logic              iIBOOT_REQ_VALID;
  logic [DQM_W-1:0]  iIBOOT_REQ_DQM;
  logic              iIBOOT_REQ_RW;
  logic [ADDR_W-1:0] iIBOOT_REQ_ADDR;
  logic [DATA_W-1:0] iIBOOT_REQ_DATA;
  logic              oIBOOT_REQ_LOCK;

  // Requester INST
  logic              iINST_REQ_VALID;
  logic [DQM_W-1:0]  iINST_REQ_DQM;
  logic              iINST_REQ_RW;
  logic [ADDR_W-1:0] iINST_REQ_ADDR;
  logic [DATA_W-1:0] iINST_REQ_DATA;
  logic              oINST_REQ_LOCK;

  // Requester DATA
  logic              iDATA_REQ_VALID;
  logic [DQM_W-1:0]  iDATA_REQ_DQM;
  logic              iDATA_REQ_RW;
  logic [ADDR_W-1:0] iDATA_REQ_ADDR;
  logic [DATA_W-1:0] iDATA_REQ_DATA;
  logic              oDATA_REQ_LOCK;

  // Memory request port
  logic              oMEM_REQ_VALID;
  logic [DQM_W-1:0]  oMEM_REQ_DQM;
  logic              oMEM_REQ_RW;
  logic [ADDR_W-1:0] oMEM_REQ_ADDR;
  logic [DATA_W-1:0] oMEM_REQ_DATA;
  logic              iMEM_REQ_LOCK;

  // Memory read responses
  logic              iMEM_RD_VALID;
  logic [DATA_W-1:0] iMEM_RD_DATA;

  // Routed responses and status
  logic              oINST_RD_VALID;
  logic              oDATA_RD_VALID;
  logic [DATA_W-1:0] oRD_DATA;
  logic              oBOOT_DONE;
  logic              oERR_ORPHAN;

  modport master (
    input  iIBOOT_VALID,
    input  iIBOOT_REQ_VALID, iIBOOT_REQ_DQM, iIBOOT_REQ_RW, iIBOOT_REQ_ADDR, iIBOOT_REQ_DATA,
    output oIBOOT_REQ_LOCK,
    input  iINST_REQ_VALID, iINST_REQ_DQM, iINST_REQ_RW, iINST_REQ_ADDR, iINST_REQ_DATA,
    output oINST_REQ_LOCK,
    input  iDATA_REQ_VALID, iDATA_REQ_DQM, iDATA_REQ_RW, iDATA_REQ_ADDR, iDATA_REQ_DATA,
    output oDATA_REQ_LOCK,
    output oMEM_REQ_VALID, oMEM_REQ_DQM, oMEM_REQ_RW, oMEM_REQ_ADDR, oMEM_REQ_DATA,
    input  iMEM_REQ_LOCK,
    input  iMEM_RD_VALID, iMEM_RD_DATA,
    output oINST_RD_VALID, oDATA_RD_VALID, oRD_DATA, oBOOT_DONE, oERR_ORPHAN
  );

  modport slave (
    output iIBOOT_VALID,
    output iIBOOT_REQ_VALID, iIBOOT_REQ_DQM, iIBOOT_REQ_RW, iIBOOT_REQ_ADDR, iIBOOT_REQ_DATA,
    input  oIBOOT_REQ_LOCK,
    output iINST_REQ_VALID, iINST_REQ_DQM, iINST_REQ_RW, iINST_REQ_ADDR, iINST_REQ_DATA,
    input  oINST_REQ_LOCK,
    output iDATA_REQ_VALID, iDATA_REQ_DQM, iDATA_REQ_RW, iDATA_REQ_ADDR, iDATA_REQ_DATA,
    input  oDATA_REQ_LOCK,
    input  oMEM_REQ_VALID, oMEM_REQ_DQM, oMEM_REQ_RW, oMEM_REQ_ADDR, oMEM_REQ_DATA,
    output iMEM_REQ_LOCK,
    output iMEM_RD_VALID, iMEM_RD_DATA,
    input  oINST_RD_VALID, oDATA_RD_VALID, oRD_DATA, oBOOT_DONE, oERR_ORPHAN
  );

endinterface

// File: rtl/memif_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// memif_arb_tag_fifo
//   Synchronous FIFO of 2-bit requester ids, one entry per outstanding read.
//   Ports:
//     clk_i, rst_i         clock, synchronous active-high reset (empties FIFO)
//     push_i, push_id_i    enqueue an id
//     pop_i                dequeue the head (ignored when empty)
//     head_id_o            id at the head (meaningful only when !empty_o)
//     full_o, empty_o      occupancy flags
//     count_o              entries held, 0..P_TAG_DEPTH
//   A push while full is taken only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module memif_arb_tag_fifo #(
  parameter int P_TAG_DEPTH   = 8,
  parameter int P_TAG_DEPTH_N = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [1:0]             push_id_i,
  input  logic                   pop_i,
  output logic [1:0]             head_id_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [P_TAG_DEPTH_N:0] count_o
);

  localparam logic [P_TAG_DEPTH_N:0] FULL_CNT = P_TAG_DEPTH[P_TAG_DEPTH_N:0];

  logic [1:0]               mem_q [P_TAG_DEPTH];
  logic [P_TAG_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_TAG_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_TAG_DEPTH_N:0]   count_q, count_d;
  logic                     do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers are exactly log2(depth) bits wide, so +1 wraps modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/memif_boot_arbiter.sv
// -----------------------------------------------------------------------------
// memif_boot_arbiter
//   Owns the single SDRAM request port. During BOOT only the boot-ROM loader
//   (IBOOT) is served; once the loader deasserts iIBOOT_VALID the arbiter
//   waits in DRAIN for all outstanding reads to return, then enters RUN where
//   INST and DATA share the port round-robin. Reads push their requester id
//   into a tag FIFO; in-order responses are routed back one cycle later.
//   Ports:
//     iCLOCK       system clock
//     iRESET_SYNC  synchronous active-high reset
//     bus          memif_boot_arbiter_if.master (requesters, memory, status)
//     oDBG_PHASE   current phase register, for observation only
// -----------------------------------------------------------------------------
module memif_boot_arbiter
  import memif_arb_pkg::*;
#(
  parameter int P_TAG_DEPTH   = 8,
  parameter int P_TAG_DEPTH_N = 3
) (
  input  logic                        iCLOCK,
  input  logic                        iRESET_SYNC,
  memif_boot_arbiter_if.master        bus,
  output phase_e                      oDBG_PHASE
);

  // Registered state
  phase_e            phase_q, phase_d;
  req_id_e           rr_last_q, rr_last_d;
  logic              inst_rd_valid_q, inst_rd_valid_d;
  logic              data_rd_valid_q, data_rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              orphan_q, orphan_d;

  // Tag FIFO
  logic                   tag_push, tag_pop;
  logic [1:0]             tag_head;
  req_id_e                tag_head_id;
  logic                   tag_full, tag_empty;
  logic [P_TAG_DEPTH_N:0] tag_count;

  // Arbitration
  mem_req_t iboot_req, inst_req, data_req, cand_req;
  logic     cand_valid;
  req_id_e  cand_id;
  logic     full_block;
  logic     accept;

  assign iboot_req = {bus.iIBOOT_REQ_DQM, bus.iIBOOT_REQ_RW, bus.iIBOOT_REQ_ADDR, bus.iIBOOT_REQ_DATA};
  assign inst_req  = {bus.iINST_REQ_DQM,  bus.iINST_REQ_RW,  bus.iINST_REQ_ADDR,  bus.iINST_REQ_DATA};
  assign data_req  = {bus.iDATA_REQ_DQM,  bus.iDATA_REQ_RW,  bus.iDATA_REQ_ADDR,  bus.iDATA_REQ_DATA};

  // Candidate selection from registered phase and round-robin pointer.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = IBOOT;
    unique case (phase_q)
      BOOT: begin
        cand_valid = bus.iIBOOT_REQ_VALID;
        cand_id    = IBOOT;
      end
      RUN: begin
        if (bus.iINST_REQ_VALID && bus.iDATA_REQ_VALID) begin
          cand_valid = 1'b1;
          cand_id    = (rr_last_q == INST) ? DATA : INST;
        end else if (bus.iINST_REQ_VALID) begin
          cand_valid = 1'b1;
          cand_id    = INST;
        end else if (bus.iDATA_REQ_VALID) begin
          cand_valid = 1'b1;
          cand_id    = DATA;
        end
      end
      default: begin
        cand_valid = 1'b0;
        cand_id    = IBOOT;
      end
    endcase
  end

  always_comb begin
    cand_req = '0;
    if (cand_valid) begin
      unique case (cand_id)
        IBOOT:   cand_req = iboot_req;
        INST:    cand_req = inst_req;
        DATA:    cand_req = data_req;
        default: cand_req = '0;
      endcase
    end
  end

  // A full tag FIFO only blocks a read when no response frees a slot this
  // same cycle; the FIFO accepts push+pop while full.
  assign tag_pop    = bus.iMEM_RD_VALID && !tag_empty;
  assign full_block = is_read(cand_req) && tag_full && !tag_pop;
  assign accept     = !iRESET_SYNC && cand_valid && !bus.iMEM_REQ_LOCK && !full_block;
  assign tag_push   = accept && is_read(cand_req);

  memif_arb_tag_fifo #(
    .P_TAG_DEPTH   (P_TAG_DEPTH),
    .P_TAG_DEPTH_N (P_TAG_DEPTH_N)
  ) u_tag_fifo (
    .clk_i     (iCLOCK),
    .rst_i     (iRESET_SYNC),
    .push_i    (tag_push),
    .push_id_i (cand_id),
    .pop_i     (tag_pop),
    .head_id_o (tag_head),
    .full_o    (tag_full),
    .empty_o   (tag_empty),
    .count_o   (tag_count)
  );

  assign tag_head_id = req_id_e'(tag_head);

  // Phase next-state. DRAIN looks at the registered count, so RUN follows
  // the cycle in which the count is seen at zero.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      BOOT:    if (!bus.iIBOOT_VALID) phase_d = DRAIN;
      DRAIN:   if (tag_count == '0)   phase_d = RUN;
      RUN:     phase_d = RUN;
      default: phase_d = BOOT;
    endcase
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept && (phase_q == RUN)) rr_last_d = cand_id;
  end

  // Response routing. IBOOT tags are consumed silently; a response with no
  // tag pending is an orphan and only raises the sticky error.
  always_comb begin
    inst_rd_valid_d = 1'b0;
    data_rd_valid_d = 1'b0;
    rd_data_d       = rd_data_q;
    orphan_d        = orphan_q;
    if (bus.iMEM_RD_VALID) begin
      if (tag_empty) begin
        orphan_d = 1'b1;
      end else if (tag_head_id == INST) begin
        inst_rd_valid_d = 1'b1;
        rd_data_d       = bus.iMEM_RD_DATA;
      end else if (tag_head_id == DATA) begin
        data_rd_valid_d = 1'b1;
        rd_data_d       = bus.iMEM_RD_DATA;
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      phase_q         <= BOOT;
      rr_last_q       <= DATA;
      inst_rd_valid_q <= 1'b0;
      data_rd_valid_q <= 1'b0;
      rd_data_q       <= '0;
      orphan_q        <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      rr_last_q       <= rr_last_d;
      inst_rd_valid_q <= inst_rd_valid_d;
      data_rd_valid_q <= data_rd_valid_d;
      rd_data_q       <= rd_data_d;
      orphan_q        <= orphan_d;
    end
  end

  // Request path: zero latency, candidate fields muxed straight through.
  assign bus.oMEM_REQ_VALID = accept;
  assign bus.oMEM_REQ_DQM   = cand_req.dqm;
  assign bus.oMEM_REQ_RW    = cand_req.rw;
  assign bus.oMEM_REQ_ADDR  = cand_req.addr;
  assign bus.oMEM_REQ_DATA  = cand_req.data;

  assign bus.oIBOOT_REQ_LOCK = !(accept && (cand_id == IBOOT));
  assign bus.oINST_REQ_LOCK  = !(accept && (cand_id == INST));
  assign bus.oDATA_REQ_LOCK  = !(accept && (cand_id == DATA));

  assign bus.oINST_RD_VALID = inst_rd_valid_q;
  assign bus.oDATA_RD_VALID = data_rd_valid_q;
  assign bus.oRD_DATA       = rd_data_q;
  assign bus.oBOOT_DONE     = (phase_q == RUN);
  assign bus.oERR_ORPHAN    = orphan_q;

  assign oDBG_PHASE = phase_q;

endmodule

// File: tb/tb_memif_boot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memif_boot_arbiter
//   Requesters are modelled as queues of pending requests; the head is
//   presented and held until granted. The reference model tracks phase,
//   round-robin owner and the outstanding-read list as plain integers and a
//   queue, predicting every output each cycle. Routed responses go through a
//   scoreboard queue of {id, data}.
// -----------------------------------------------------------------------------
module tb_memif_boot_arbiter;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0]  dqm;
    logic        rw;
    logic [24:0] addr;
    logic [31:0] data;
  } req_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memif_boot_arbiter_if bus ();
  logic [1:0] dbg_phase;

  memif_boot_arbiter #(
    .P_TAG_DEPTH   (8),
    .P_TAG_DEPTH_N (3)
  ) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .bus         (bus),
    .oDBG_PHASE  (dbg_phase)
  );

  // Stimulus state
  req_t iboot_q[$];
  req_t inst_q[$];
  req_t data_q[$];
  req_t cur [3];
  logic cur_v [3];
  logic        iboot_v;
  logic        mem_lock;
  logic        rsp_v;
  logic [31:0] rsp_data;

  // Reference model
  int          m_phase;     // 0 boot, 1 drain, 2 run
  int          m_rr_last;   // 1 inst, 2 data
  int          m_tags[$];   // ids of outstanding reads, oldest first
  logic        m_orphan;
  logic [31:0] m_rd_data;
  logic        m_rd_known;
  logic [33:0] exp_q[$];    // {id, data} routed response due next cycle

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input logic rw, input logic [24:0] addr, input logic [31:0] data);
    req_t r;
    r.dqm  = 4'hF;
    r.rw   = rw;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.dqm  = 4'($urandom_range(0, 15));
    r.rw   = 1'($urandom_range(0, 1));
    r.addr = 25'($urandom());
    r.data = $urandom();
    return r;
  endfunction

  // Driver tasks
  task automatic load_reqs();
    if (!cur_v[0] && iboot_q.size() > 0) begin cur[0] = iboot_q.pop_front(); cur_v[0] = 1'b1; end
    if (!cur_v[1] && inst_q.size()  > 0) begin cur[1] = inst_q.pop_front();  cur_v[1] = 1'b1; end
    if (!cur_v[2] && data_q.size()  > 0) begin cur[2] = data_q.pop_front();  cur_v[2] = 1'b1; end
  endtask

  task automatic drive();
    bus.iIBOOT_VALID     = iboot_v;
    bus.iIBOOT_REQ_VALID = cur_v[0];
    bus.iIBOOT_REQ_DQM   = cur[0].dqm;
    bus.iIBOOT_REQ_RW    = cur[0].rw;
    bus.iIBOOT_REQ_ADDR  = cur[0].addr;
    bus.iIBOOT_REQ_DATA  = cur[0].data;
    bus.iINST_REQ_VALID  = cur_v[1];
    bus.iINST_REQ_DQM    = cur[1].dqm;
    bus.iINST_REQ_RW     = cur[1].rw;
    bus.iINST_REQ_ADDR   = cur[1].addr;
    bus.iINST_REQ_DATA   = cur[1].data;
    bus.iDATA_REQ_VALID  = cur_v[2];
    bus.iDATA_REQ_DQM    = cur[2].dqm;
    bus.iDATA_REQ_RW     = cur[2].rw;
    bus.iDATA_REQ_ADDR   = cur[2].addr;
    bus.iDATA_REQ_DATA   = cur[2].data;
    bus.iMEM_REQ_LOCK    = mem_lock;
    bus.iMEM_RD_VALID    = rsp_v;
    bus.iMEM_RD_DATA     = rsp_data;
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance model.
  task automatic step();
    int          cand;
    logic        acc;
    int          cnt0;
    int          id;
    logic [33:0] e;
    logic        exp_i, exp_d;
    load_reqs();
    drive();
    @(negedge clk);

    cand = -1;
    if (m_phase == 0) begin
      if (cur_v[0]) cand = 0;
    end else if (m_phase == 2) begin
      if (cur_v[1] && cur_v[2]) cand = (m_rr_last == 1) ? 2 : 1;
      else if (cur_v[1])        cand = 1;
      else if (cur_v[2])        cand = 2;
    end
    acc = 1'b0;
    if (!rst && cand >= 0 && !mem_lock) begin
      if (cur[cand].rw || m_tags.size() < DEPTH || rsp_v) acc = 1'b1;
    end

    check("mem_valid", bus.oMEM_REQ_VALID, acc);
    if (acc) begin
      check("mem_rw",   bus.oMEM_REQ_RW,   cur[cand].rw);
      check("mem_addr", bus.oMEM_REQ_ADDR, cur[cand].addr);
      check("mem_data", bus.oMEM_REQ_DATA, cur[cand].data);
      check("mem_dqm",  bus.oMEM_REQ_DQM,  cur[cand].dqm);
    end
    check("iboot_lock", bus.oIBOOT_REQ_LOCK, !(acc && cand == 0));
    check("inst_lock",  bus.oINST_REQ_LOCK,  !(acc && cand == 1));
    check("data_lock",  bus.oDATA_REQ_LOCK,  !(acc && cand == 2));
    check("phase",      dbg_phase,           m_phase);
    check("boot_done",  bus.oBOOT_DONE,      m_phase == 2);
    check("orphan",     bus.oERR_ORPHAN,     m_orphan);

    exp_i = 1'b0;
    exp_d = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_i = (e[33:32] == 2'd1);
      exp_d = (e[33:32] == 2'd2);
      m_rd_data  = e[31:0];
      m_rd_known = 1'b1;
    end
    check("inst_rd_valid", bus.oINST_RD_VALID, exp_i);
    check("data_rd_valid", bus.oDATA_RD_VALID, exp_d);
    if (m_rd_known) check("rd_data", bus.oRD_DATA, m_rd_data);

    cnt0 = m_tags.size();
    if (rst) begin
      m_phase    = 0;
      m_rr_last  = 2;
      m_tags.delete();
      m_orphan   = 1'b0;
      exp_q.delete();
      m_rd_known = 1'b0;
    end else begin
      if (rsp_v) begin
        if (cnt0 == 0) m_orphan = 1'b1;
        else begin
          id = m_tags.pop_front();
          if (id != 0) exp_q.push_back({id[1:0], rsp_data});
        end
      end
      if (acc && !cur[cand].rw) m_tags.push_back(cand);
      if (acc && m_phase == 2)  m_rr_last = cand;
      if (m_phase == 0 && !iboot_v)      m_phase = 1;
      else if (m_phase == 1 && cnt0 == 0) m_phase = 2;
    end
    if (acc) cur_v[cand] = 1'b0;

    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (m_tags.size() == 0 && inst_q.size() == 0 && data_q.size() == 0 && !cur_v[1] && !cur_v[2]) break;
      mem_lock = 1'b0;
      rsp_v    = (m_tags.size() > 0);
      rsp_data = $urandom();
      step();
    end
    rsp_v = 1'b0;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin cur[i] = '0; cur_v[i] = 1'b0; end
    rst = 1'b1; iboot_v = 1'b1; mem_lock = 1'b0; rsp_v = 1'b0; rsp_data = '0;
    m_phase = 0; m_rr_last = 2; m_orphan = 1'b0; m_rd_data = '0; m_rd_known = 1'b0;
    drive();
    @(posedge clk);
    #1;

    // Boot: 4 writes then 2 reads from the loader; INST/DATA wait locked.
    for (int i = 0; i < 4; i++) iboot_q.push_back(mk_req(1'b1, 25'(i), 32'hA0 + 32'(i)));
    iboot_q.push_back(mk_req(1'b0, 25'h100, 32'h0));
    iboot_q.push_back(mk_req(1'b0, 25'h101, 32'h0));
    inst_q.push_back(mk_req(1'b0, 25'h40, 32'h0));
    data_q.push_back(mk_req(1'b1, 25'h50, 32'h55));
    repeat (3) step();
    rst = 1'b0;
    repeat (8) step();

    // Loader finishes with 2 reads outstanding: DRAIN until both return.
    iboot_v = 1'b0;
    repeat (3) step();
    rsp_v = 1'b1; rsp_data = 32'hB001; step();
    rsp_data = 32'hB002; step();
    rsp_v = 1'b0;
    repeat (3) step();
    drain(20);

    // Round-robin with a 3-cycle memory stall.
    for (int i = 0; i < 4; i++) begin
      inst_q.push_back(mk_req(1'b1, 25'h200 + 25'(i), 32'h1000 + 32'(i)));
      data_q.push_back(mk_req(1'b1, 25'h300 + 25'(i), 32'h2000 + 32'(i)));
    end
    repeat (2) step();
    mem_lock = 1'b1;
    repeat (3) step();
    mem_lock = 1'b0;
    repeat (8) step();

    // Tag FIFO full: 8 DATA reads, then a 9th read alongside an INST write.
    for (int i = 0; i < DEPTH; i++) data_q.push_back(mk_req(1'b0, 25'h400 + 25'(i), 32'h0));
    repeat (9) step();
    data_q.push_back(mk_req(1'b0, 25'h408, 32'h0));
    inst_q.push_back(mk_req(1'b1, 25'h500, 32'hCAFE));
    repeat (3) step();
    rsp_v = 1'b1; rsp_data = 32'hD0; step();
    rsp_v = 1'b0;
    repeat (2) step();
    drain(30);

    // Routing: INST, DATA, INST reads answered back to back.
    inst_q.push_back(mk_req(1'b0, 25'h10, 32'h0)); repeat (2) step();
    data_q.push_back(mk_req(1'b0, 25'h20, 32'h0)); repeat (2) step();
    inst_q.push_back(mk_req(1'b0, 25'h30, 32'h0)); repeat (2) step();
    rsp_v = 1'b1;
    rsp_data = 32'h11; step();
    rsp_data = 32'h22; step();
    rsp_data = 32'h33; step();
    rsp_v = 1'b0;
    repeat (2) step();

    // Randomized traffic in RUN, including loader-valid noise.
    for (int c = 0; c < 400; c++) begin
      if (inst_q.size() < 2 && $urandom_range(0, 2) == 0) inst_q.push_back(rand_req());
      if (data_q.size() < 2 && $urandom_range(0, 2) == 0) data_q.push_back(rand_req());
      mem_lock = ($urandom_range(0, 4) == 0);
      rsp_v    = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
      rsp_data = $urandom();
      iboot_v  = 1'($urandom_range(0, 1));
      step();
    end
    iboot_v = 1'b0;
    drain(60);

    // Orphan response: sticky error.
    rsp_v = 1'b1; rsp_data = 32'hDEAD; step();
    rsp_v = 1'b0;
    repeat (3) step();

    // Reset mid-operation with reads pending; late responses become orphans.
    for (int i = 0; i < 3; i++) inst_q.push_back(mk_req(1'b0, 25'h600 + 25'(i), 32'h0));
    repeat (4) step();
    iboot_v = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    rsp_v = 1'b1;
    for (int i = 0; i < 3; i++) begin rsp_data = 32'hE0 + 32'(i); step(); end
    rsp_v = 1'b0;
    repeat (2) step();
    iboot_v = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memif_boot_arbiter.md
Name: memif_boot_arbiter

Overview:
- Owns the single SDRAM memory-interface request port.
- Shares the port between three requesters: the boot-ROM loader (IBOOT), CPU instruction fetch (INST) and CPU data access (DATA).
- Sequences a boot phase, during which only IBOOT is served, followed by a run phase with round-robin arbitration between INST and DATA.
- Routes in-order read responses back to their issuer through a tag FIFO.

Parameters:
- P_TAG_DEPTH, 8, maximum outstanding reads; power of two, at least 2.
- P_TAG_DEPTH_N, 3, log2(P_TAG_DEPTH).

Ports:
- iCLOCK  in  1  system clock
- iRESET_SYNC  in  1  synchronous active-high reset
- iIBOOT_VALID  in  1  loader still active; boot phase holds while high
- iIBOOT_REQ_VALID / iINST_REQ_VALID / iDATA_REQ_VALID  in  1 each  request strobe
- iX_REQ_DQM  in  4  byte masks per requester (X = IBOOT, INST, DATA)
- iX_REQ_RW  in  1  0: read, 1: write
- iX_REQ_ADDR  in  25  word address
- iX_REQ_DATA  in  32  write data
- oX_REQ_LOCK  out  1  backpressure to requester X
- oMEM_REQ_VALID  out  1  request to memory
- oMEM_REQ_DQM  out  4  byte masks to memory
- oMEM_REQ_RW  out  1  read/write to memory
- oMEM_REQ_ADDR  out  25  address to memory
- oMEM_REQ_DATA  out  32  write data to memory
- iMEM_REQ_LOCK  in  1  memory backpressure
- iMEM_RD_VALID  in  1  read response strobe, in issue order
- iMEM_RD_DATA  in  32  read response data
- oINST_RD_VALID / oDATA_RD_VALID  out  1 each  routed read response strobe
- oRD_DATA  out  32  read data, shared by both routed responses
- oBOOT_DONE  out  1  high once the run phase is entered
- oERR_ORPHAN  out  1  sticky error: read response arrived with no tag pending

Behaviour:
- Reset is synchronous. While iRESET_SYNC is high:
  - phase = BOOT, tag FIFO empty, round-robin last = DATA (so INST wins the first tie);
  - oBOOT_DONE = 0, oERR_ORPHAN = 0, all oX_REQ_LOCK = 1, oMEM_REQ_VALID = 0, oINST_RD_VALID = oDATA_RD_VALID = 0.
- Phase FSM (registered):
  - BOOT -> DRAIN on the first cycle iIBOOT_VALID is sampled low.
  - DRAIN -> RUN when the outstanding count is 0; this may happen in the same cycle DRAIN is entered if the count is already 0.
  - RUN is terminal until reset.
  - oBOOT_DONE = (phase == RUN).
- Candidate selection, combinational from registered state:
  - BOOT: candidate = IBOOT.
  - DRAIN: no candidate.
  - RUN: if only one of INST/DATA is valid, it is the candidate; if both are valid, the one not equal to rr_last.
- Acceptance: in cycle t, accept = candidate valid && !iMEM_REQ_LOCK && !(candidate RW = read && tag FIFO full).
- Request path latency is 0:
  - oMEM_REQ_* equals the candidate's fields muxed through;
  - oMEM_REQ_VALID = accept.
- Lock rules:
  - oX_REQ_LOCK = !(X is candidate && accept).
  - A requester holds its fields stable while locked.
  - Non-candidates are always locked; INST and DATA are locked for all of BOOT and DRAIN.
- rr_last updates to the granted id only on an accepted RUN request; it is unchanged otherwise.
- Tag FIFO:
  - Push on accepted read, storing the 2-bit requester id.
  - Pop on iMEM_RD_VALID.
  - Simultaneous push and pop keeps the count; when full, a push with a pop in the same cycle is allowed.
  - Pointers wrap modulo P_TAG_DEPTH. The count is P_TAG_DEPTH_N+1 bits wide.
- Response routing, registered, 1-cycle latency (iMEM_RD_* at t -> outputs at t+1):
  - oINST_RD_VALID / oDATA_RD_VALID is asserted according to the head tag; oRD_DATA takes iMEM_RD_DATA.
  - A head tag of IBOOT is popped and dropped, with no output strobe.
  - oRD_DATA holds its value when no strobe is asserted.
- Orphan response: iMEM_RD_VALID with the FIFO empty sets oERR_ORPHAN (sticky until reset); no pop, no strobe.
- Writes never push a tag.
- iIBOOT_VALID going high again during RUN has no effect.
- Reset mid-operation discards all pending tags; responses for those reads arriving after reset are orphans.

Decomposition:
- Package memif_arb_pkg holds:
  - requester id enum: IBOOT = 2'd0, INST = 2'd1, DATA = 2'd2;
  - phase enum: BOOT, DRAIN, RUN;
  - widths: address 25, data 32, DQM 4.
- Sub-module memif_arb_tag_fifo: synchronous FIFO of 2-bit ids with P_TAG_DEPTH entries, push/pop/full/empty/count, synchronous active-high reset.

Test Plan:
- Boot: IBOOT writes addr 0..3 with data 32'hA0..A3, iMEM_REQ_LOCK = 0 -> 4 memory writes in order. INST/DATA valid throughout -> locked; oBOOT_DONE = 0.
- Boot end with reads outstanding:
  - Setup: in RUN-equivalent reset flow, force 2 IBOOT reads, then drop iIBOOT_VALID -> phase stays DRAIN.
  - Return 2 responses -> both dropped, with no INST/DATA strobe.
  - The cycle after the count reaches 0 -> RUN, oBOOT_DONE = 1.
- Round-robin: INST and DATA both valid continuously in RUN -> grants alternate INST, DATA, INST, DATA starting with INST.
- Memory lock: a stall of iMEM_REQ_LOCK = 1 for 3 cycles mid-sequence -> no grant and rr_last unchanged during the stall.
- Tag full:
  - Issue 8 DATA reads with no responses -> the 9th read is locked, while a concurrent INST write is still accepted.
  - One response returns -> 9th read accepted the cycle the pop occurs.
- Routing: reads issued in order INST@0x10, DATA@0x20, INST@0x30; responses 32'h11, 32'h22, 32'h33 -> oINST_RD_VALID with 11, oDATA_RD_VALID with 22, oINST_RD_VALID with 33, each 1 cycle after its input.
- Orphan and reset:
  - iMEM_RD_VALID with the FIFO empty -> oERR_ORPHAN = 1 and held.
  - iRESET_SYNC pulse -> oERR_ORPHAN = 0, phase BOOT, all outputs back to reset values.
